// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement engine.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } meas_state_t;

  // Bit positions inside the 2-bit challenge configuration field.
  localparam int CFG_SEL_BIT = 0;
  localparam int CFG_BX_BIT  = 1;

endpackage

// File: rtl/ro_edge_counter.sv
// Rising-edge counter for one synchronised oscillator: third-stage delay,
// edge detect and a saturating counter that never wraps.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_bit,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic delay_q;
  logic rise;

  assign rise = sync_bit & ~delay_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q <= 1'b0;
      count   <= '0;
    end else begin
      delay_q <= sync_bit;
      if (clear) begin
        count <= '0;
      end else if (enable && rise && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_puf_pair_meas.sv
// Ring-oscillator PUF pair measurement: enables a challenged pair, lets it
// settle, counts edges over a fixed window and reports which one ran faster.
module ro_puf_pair_meas
  import puf_pkg::*;
#(
  parameter int NUM_RO = 16,
  parameter int IDX_W  = $clog2(NUM_RO),
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CHAL_VALID,
  output logic              CHAL_READY,
  input  logic [IDX_W-1:0]  CHAL_A,
  input  logic [IDX_W-1:0]  CHAL_B,
  input  logic [1:0]        CHAL_CFG,
  input  logic [NUM_RO-1:0] RO_IN,
  output logic [NUM_RO-1:0] RO_EN,
  output logic              RO_SEL,
  output logic              RO_BX,
  output logic              RESP_VALID,
  input  logic              RESP_READY,
  output logic              RESP,
  output logic              RESP_TIE,
  output logic              RESP_ERR,
  output logic [CNT_W-1:0]  CNT_A,
  output logic [CNT_W-1:0]  CNT_B
);

  localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int EXT_W   = 2 ** IDX_W;
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [NUM_RO-1:0] RO_ONE      = NUM_RO'(1);

  meas_state_t       state_q, state_d;
  logic [TMR_W-1:0]  timer_q;
  logic [IDX_W-1:0]  a_q, b_q, a_d, b_d;
  logic [NUM_RO-1:0] sync1_q, sync2_q, ro_en_q, pair_mask;
  logic [EXT_W-1:0]  sync_ext;
  logic              sel_q, bx_q, resp_q, tie_q, err_q;
  logic              accept, illegal, cnt_clear, cnt_enable;
  logic [CNT_W-1:0]  cnt_a, cnt_b;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= RO_IN;
      sync2_q <= sync1_q;
    end
  end

  // Zero-extend so any IDX_W-wide index selects a defined bit.
  assign sync_ext = EXT_W'(sync2_q);

  assign accept  = CHAL_VALID && (state_q == IDLE);
  assign illegal = (CHAL_A == CHAL_B) || (int'(CHAL_A) >= NUM_RO) || (int'(CHAL_B) >= NUM_RO);
  assign a_d     = accept ? CHAL_A : a_q;
  assign b_d     = accept ? CHAL_B : b_q;
  assign pair_mask = (RO_ONE << a_d) | (RO_ONE << b_d);

  // The SETTLE parameter shadows the imported state name, hence the qualifier.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:             if (CHAL_VALID) state_d = illegal ? DONE : puf_pkg::SETTLE;
      puf_pkg::SETTLE:  if (timer_q == SETTLE_LAST) state_d = COUNT;
      COUNT:            if (timer_q == WINDOW_LAST) state_d = COMPARE;
      COMPARE:          state_d = DONE;
      DONE:             if (RESP_READY) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ro_en_q <= '0;
      sel_q   <= 1'b0;
      bx_q    <= 1'b0;
      resp_q  <= 1'b0;
      tie_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= (state_d != state_q) ? '0 : timer_q + TMR_W'(1);
      // Registered enable keeps the oscillator gates glitch-free.
      ro_en_q <= ((state_d == puf_pkg::SETTLE) || (state_d == COUNT)) ? pair_mask : '0;
      if (accept) begin
        a_q    <= CHAL_A;
        b_q    <= CHAL_B;
        resp_q <= 1'b0;
        tie_q  <= 1'b0;
        err_q  <= illegal;
        if (!illegal) begin
          sel_q <= CHAL_CFG[CFG_SEL_BIT];
          bx_q  <= CHAL_CFG[CFG_BX_BIT];
        end
      end else if (state_q == COMPARE) begin
        resp_q <= (cnt_a > cnt_b);
        tie_q  <= (cnt_a == cnt_b);
      end
    end
  end

  // Clearing on accept also zeroes the counts reported for an illegal challenge.
  assign cnt_clear  = accept || (state_q == puf_pkg::SETTLE);
  assign cnt_enable = (state_q == COUNT);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk      (CLK),
    .rst_n    (RST_N),
    .sync_bit (sync_ext[a_q]),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .count    (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk      (CLK),
    .rst_n    (RST_N),
    .sync_bit (sync_ext[b_q]),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .count    (cnt_b)
  );

  assign CHAL_READY = (state_q == IDLE);
  assign RESP_VALID = (state_q == DONE);
  assign RO_EN      = ro_en_q;
  assign RO_SEL     = sel_q;
  assign RO_BX      = bx_q;
  assign RESP       = resp_q;
  assign RESP_TIE   = tie_q;
  assign RESP_ERR   = err_q;
  assign CNT_A      = cnt_a;
  assign CNT_B      = cnt_b;

endmodule

// File: tb/tb_ro_puf_pair_meas.sv
// Scoreboard bench for ro_puf_pair_meas: a driver issues challenges against
// synthetic periodic oscillators, a monitor checks each response it presents.
module tb_ro_puf_pair_meas;

  localparam int NUM_RO  = 16;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 4;
  localparam int SETTLE  = 4;
  localparam int WINDOW  = 64;
  localparam int CNT_MAX = 2 ** CNT_W - 1;
  localparam int LAT     = SETTLE + WINDOW + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              chal_valid = 1'b0;
  logic              chal_ready;
  logic [IDX_W-1:0]  chal_a = '0;
  logic [IDX_W-1:0]  chal_b = '0;
  logic [1:0]        chal_cfg = '0;
  logic [NUM_RO-1:0] ro_in = '0;
  logic [NUM_RO-1:0] ro_en;
  logic              ro_sel, ro_bx, resp_valid, resp, resp_tie, resp_err;
  logic              resp_ready = 1'b0;
  logic [CNT_W-1:0]  cnt_a, cnt_b;

  ro_puf_pair_meas #(
    .NUM_RO (NUM_RO),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W),
    .WINDOW (WINDOW),
    .SETTLE (SETTLE)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .CHAL_VALID (chal_valid),
    .CHAL_READY (chal_ready),
    .CHAL_A     (chal_a),
    .CHAL_B     (chal_b),
    .CHAL_CFG   (chal_cfg),
    .RO_IN      (ro_in),
    .RO_EN      (ro_en),
    .RO_SEL     (ro_sel),
    .RO_BX      (ro_bx),
    .RESP_VALID (resp_valid),
    .RESP_READY (resp_ready),
    .RESP       (resp),
    .RESP_TIE   (resp_tie),
    .RESP_ERR   (resp_err),
    .CNT_A      (cnt_a),
    .CNT_B      (cnt_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synthetic oscillators: period in CLK cycles (0 = held low), all phase-aligned.
  int period [NUM_RO] = '{default: 0};
  int ro_t = 0;
  always @(negedge clk) begin
    ro_t <= ro_t + 1;
    for (int i = 0; i < NUM_RO; i++)
      ro_in[i] <= (period[i] != 0) && ((ro_t % period[i]) < period[i] / 2);
  end

  typedef struct {
    int acc;
    int lat;
    bit err;
    bit resp;
    bit tie;
    int na;
    int nb;
    int hold;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   last_sel = 1'b0;
  bit   last_bx = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Edges in the window: WINDOW/period for a periodic input, clipped at saturation.
  function automatic int nominal(input int p);
    int n;
    if (p == 0) return 0;
    n = WINDOW / p;
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  function automatic int lo_of(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

  function automatic int hi_of(input int n);
    return (n < CNT_MAX) ? n + 1 : CNT_MAX;
  endfunction

  function automatic int pick_period();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 4;
      2:       return 8;
      3:       return 16;
      default: return 32;
    endcase
  endfunction

  task automatic run_txn(input int a, input int b, input int pa, input int pb,
                         input logic [1:0] cfg, input int hold, input int abort_at,
                         input bit busy_offer);
    exp_t              e;
    int                w;
    logic [NUM_RO-1:0] m;
    bit                err;
    err = (a == b) || (a >= NUM_RO) || (b >= NUM_RO);
    @(negedge clk);
    for (int i = 0; i < NUM_RO; i++) period[i] = 4 << $urandom_range(0, 3);
    if (a < NUM_RO) period[a] = pa;
    if (b < NUM_RO) period[b] = pb;
    chal_a = IDX_W'(a);
    chal_b = IDX_W'(b);
    chal_cfg = cfg;
    chal_valid = 1'b1;
    w = 0;
    while (!chal_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!chal_ready) begin
      check("accept_timeout", 0, 1);
      chal_valid = 1'b0;
      return;
    end
    e.acc  = cyc;
    e.lat  = err ? 1 : LAT;
    e.err  = err;
    e.na   = err ? 0 : nominal(pa);
    e.nb   = err ? 0 : nominal(pb);
    e.resp = !err && (e.na > e.nb);
    e.tie  = !err && (e.na == e.nb);
    e.hold = hold;
    if (abort_at == 0) sb.push_back(e);
    @(negedge clk);
    chal_valid = 1'b0;
    if (!err) begin
      last_sel = cfg[0];
      last_bx  = cfg[1];
    end
    check("ro_sel", ro_sel, last_sel);
    check("ro_bx", ro_bx, last_bx);
    m = '0;
    if (err) begin
      check("ro_en_err", ro_en, 0);
      return;
    end
    m[a] = 1'b1;
    m[b] = 1'b1;
    for (int k = 1; k <= SETTLE + WINDOW + 1; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_sel = 1'b0;
        last_bx  = 1'b0;
        check("abort_ro_en", ro_en, 0);
        check("abort_cnt_a", cnt_a, 0);
        check("abort_cnt_b", cnt_b, 0);
        check("abort_chal_ready", chal_ready, 1);
        check("abort_resp_valid", resp_valid, 0);
        return;
      end
      check($sformatf("ro_en_c%0d", k), ro_en, (k <= SETTLE + WINDOW) ? int'(m) : 0);
      if (k < SETTLE + WINDOW + 1) @(negedge clk);
    end
    if (busy_offer) begin
      chal_a = 0;
      chal_b = 1;
      chal_valid = 1'b1;
      for (int j = 0; j < 8; j++) begin
        check("busy_chal_ready", chal_ready, 0);
        @(negedge clk);
      end
      chal_valid = 1'b0;
    end
  endtask

  // Monitor: compares each response the DUT presents against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 0, 1);
        end else begin
          e = sb.pop_front();
          check("latency", cyc - e.acc, e.lat);
          check("resp", resp, e.resp);
          check("resp_tie", resp_tie, e.tie);
          check("resp_err", resp_err, e.err);
          check_rng("cnt_a", cnt_a, lo_of(e.na), hi_of(e.na));
          check_rng("cnt_b", cnt_b, lo_of(e.nb), hi_of(e.nb));
          for (int h = 0; h < e.hold; h++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_chal_ready", chal_ready, 0);
            check("hold_resp", resp, e.resp);
            check("hold_tie", resp_tie, e.tie);
            check("hold_err", resp_err, e.err);
            check_rng("hold_cnt_a", cnt_a, lo_of(e.na), hi_of(e.na));
            check_rng("hold_cnt_b", cnt_b, lo_of(e.nb), hi_of(e.nb));
          end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle_chal_ready", chal_ready, 1);
        check("valid_drop", resp_valid, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, pa, pb, w;
    repeat (3) @(negedge clk);
    check("rst_ro_en", ro_en, 0);
    check("rst_chal_ready", chal_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp", resp, 0);
    check("rst_tie", resp_tie, 0);
    check("rst_err", resp_err, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_cnt_b", cnt_b, 0);
    check("rst_ro_sel", ro_sel, 0);
    check("rst_ro_bx", ro_bx, 0);
    rst_n = 1'b1;

    run_txn(3, 5, 8, 16, 2'b10, 2, 0, 1'b0);    // basic A faster
    run_txn(1, 2, 0, 0, 2'b01, 0, 0, 1'b0);     // both silent: tie
    run_txn(7, 7, 8, 8, 2'b11, 1, 0, 1'b0);     // same index: error
    run_txn(16, 2, 8, 8, 2'b00, 0, 0, 1'b0);    // out-of-range index: error
    run_txn(0, 9, 4, 16, 2'b11, 0, 0, 1'b0);    // A saturates at CNT_MAX
    run_txn(4, 6, 32, 8, 2'b01, 10, 0, 1'b1);   // long hold, busy offer ignored
    run_txn(3, 5, 8, 16, 2'b10, 0, 30, 1'b0);   // reset mid-count aborts
    repeat (LAT + 10) @(negedge clk);
    check("abort_no_resp", resp_valid, 0);

    for (int n = 0; n < 14; n++) begin
      a  = $urandom_range(0, 17);
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, 17);
      pa = pick_period();
      pb = ($urandom_range(0, 3) == 0) ? pa : pick_period();
      run_txn(a, b, pa, pb, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 0, 1'b0);
    end

    w = 0;
    while ((sb.size() != 0 || resp_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
